rpn_calc_core: RTL and testbench

Parametrised RPN calculator datapath. It replaces the fixed two-operand buffer pair and combinational ALU with a DEPTH-entry operand stack, multi-digit decimal entry, and a multi-cycle signed multiplier. It sits between the keypad/opcode encoders, which supply one-cycle key strobes, and the seven-segment/LED drivers, which consume `top` and the flags.

---
 rtl/rpn_pkg.sv | 21 ++
 rtl/rpn_calc_core_if.sv | 28 ++
 rtl/rpn_seq_mul.sv | 56 +++++
 rtl/rpn_calc_core.sv | 250 +++++++++++++++++++++++++
 tb/tb_rpn_calc_core.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: key codes, FSM state type and entry radix shared by the RPN calculator.
package rpn_pkg;

  localparam int unsigned KEY_W = 5;
  localparam int unsigned RADIX = 10;

  localparam logic [KEY_W-1:0] KEY_ADD   = KEY_W'(10);
  localparam logic [KEY_W-1:0] KEY_SUB   = KEY_W'(11);
  localparam logic [KEY_W-1:0] KEY_MUL   = KEY_W'(12);
  localparam logic [KEY_W-1:0] KEY_NEG   = KEY_W'(13);
  localparam logic [KEY_W-1:0] KEY_ENTER = KEY_W'(14);
  localparam logic [KEY_W-1:0] KEY_DROP  = KEY_W'(15);
  localparam logic [KEY_W-1:0] KEY_CLEAR = KEY_W'(16);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } rpn_state_t;

endpackage

// File: rtl/rpn_calc_core_if.sv
// rpn_calc_core_if: key strobe input and display/flag outputs of the RPN calculator.
interface rpn_calc_core_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  import rpn_pkg::*;

  logic                         key_valid;
  logic [KEY_W-1:0]             key_code;
  logic                         key_ready;
  logic                         busy;
  logic [WIDTH-1:0]             top;
  logic [$clog2(DEPTH+1)-1:0]   depth_cnt;
  logic                         o_flag;
  logic                         err;

  // keypad/display side
  modport master (
    output key_valid, key_code,
    input  key_ready, busy, top, depth_cnt, o_flag, err
  );

  // calculator core side
  modport slave (
    input  key_valid, key_code,
    output key_ready, busy, top, depth_cnt, o_flag, err
  );
endinterface

// File: rtl/rpn_seq_mul.sv
// rpn_seq_mul: unsigned WIDTH x WIDTH shift-add multiplier, one multiplier bit per
// cycle. Only built when RPN_MUL_EN is defined. The load edge already consumes
// bit 0, so done pulses WIDTH-1 cycles after start.
`ifdef RPN_MUL_EN
module rpn_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             run;

  // load with first partial product, then accumulate one bit per cycle
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      run     <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= PW'(a) << 1;
        mplier  <= b >> 1;
        product <= b[0] ? PW'(a) : '0;
        cnt     <= CW'(WIDTH - 1);
        run     <= 1'b1;
      end else if (run) begin
        if (mplier[0]) begin
          product <= product + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule
`endif

// File: rtl/rpn_calc_core.sv
// rpn_calc_core: RPN calculator datapath -- DEPTH-entry operand stack, decimal
// digit entry, ADD/SUB/NEG/DROP/MUL. Define RPN_MUL_EN to build the sequential
// multiplier; without it MUL is rejected with err.
module rpn_calc_core
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           nrst,
  rpn_calc_core_if.slave bus
);
  localparam int unsigned DW = $clog2(DEPTH + 1);
  localparam int unsigned EW = WIDTH + 4;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW-1:0]    FULL    = DW'(DEPTH);

  rpn_state_t                  state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0] stack_q, stack_d;
  logic [DW-1:0]               depth_q, depth_d;
  logic [WIDTH-1:0]            entry_q, entry_d;
  logic                        entering_q, entering_d;
  logic [KEY_W-1:0]            op_q, op_d;
  logic                        o_flag_q, o_flag_d;
  logic                        err_q, err_d;
  logic [WIDTH-1:0]            top_q, top_d;
  logic                        key_ready_q, busy_q;
  logic [WIDTH-1:0]            opa, opb, res;
  logic [EW-1:0]               ext;
  logic                        b_sign;

  assign opb = stack_q[0];
  assign opa = stack_q[1];

`ifdef RPN_MUL_EN
  logic               mul_start, mul_done, mul_neg_q, mul_neg_d;
  logic [2*WIDTH-1:0] mul_prod, sprod;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign mag_a = opa[WIDTH-1] ? -opa : opa;
  assign mag_b = opb[WIDTH-1] ? -opb : opb;
  assign sprod = mul_neg_q ? -mul_prod : mul_prod;

  rpn_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .nrst    (nrst),
    .start   (mul_start),
    .a       (mag_a),
    .b       (mag_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // product sign, captured when the magnitudes are loaded
  always_ff @(posedge clk) begin
    if (!nrst) mul_neg_q <= 1'b0;
    else       mul_neg_q <= mul_neg_d;
  end
`endif

  // next state, stack update and flag logic
  always_comb begin
    state_d    = state_q;
    stack_d    = stack_q;
    depth_d    = depth_q;
    entry_d    = entry_q;
    entering_d = entering_q;
    op_d       = op_q;
    o_flag_d   = o_flag_q;
    err_d      = err_q;
    ext        = '0;
    res        = '0;
    b_sign     = 1'b0;
`ifdef RPN_MUL_EN
    mul_start  = 1'b0;
    mul_neg_d  = mul_neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          if (bus.key_code < KEY_ADD) begin
            ext = EW'(entry_q) * EW'(RADIX) + EW'(bus.key_code);
            if (ext > EW'(MAX_POS)) begin
              entry_d  = MAX_POS;
              o_flag_d = 1'b1;
            end else begin
              entry_d = ext[WIDTH-1:0];
            end
            entering_d = 1'b1;
          end else if (bus.key_code == KEY_CLEAR) begin
            stack_d    = '0;
            depth_d    = '0;
            entry_d    = '0;
            entering_d = 1'b0;
            o_flag_d   = 1'b0;
            err_d      = 1'b0;
          end else if (bus.key_code == KEY_ENTER) begin
            if (entering_q) begin
              entering_d = 1'b0;
              entry_d    = '0;
              if (depth_q == FULL) begin
                err_d = 1'b1;
              end else begin
                stack_d = {stack_q[DEPTH-2:0], entry_q};
                depth_d = depth_q + DW'(1);
              end
            end else if (depth_q != '0) begin
              if (depth_q == FULL) begin
                err_d = 1'b1;
              end else begin
                stack_d = {stack_q[DEPTH-2:0], stack_q[0]};
                depth_d = depth_q + DW'(1);
              end
            end
          end else if (bus.key_code < KEY_CLEAR) begin
            // operator or DROP: push a pending entry first, abort if no room
            op_d = bus.key_code;
            if (entering_q) begin
              entering_d = 1'b0;
              entry_d    = '0;
              if (depth_q == FULL) begin
                err_d = 1'b1;
              end else begin
                stack_d = {stack_q[DEPTH-2:0], entry_q};
                depth_d = depth_q + DW'(1);
                state_d = EXEC;
              end
            end else begin
              state_d = EXEC;
            end
          end
        end
      end

      EXEC: begin
        state_d = IDLE;
        case (op_q)
          KEY_ADD, KEY_SUB: begin
            if (depth_q < DW'(2)) begin
              err_d = 1'b1;
            end else begin
              res    = (op_q == KEY_ADD) ? opa + opb : opa - opb;
              b_sign = (op_q == KEY_ADD) ? opb[WIDTH-1] : ~opb[WIDTH-1];
              if ((opa[WIDTH-1] == b_sign) && (res[WIDTH-1] != opa[WIDTH-1])) begin
                o_flag_d = 1'b1;
              end
              stack_d    = {{WIDTH{1'b0}}, stack_q[DEPTH-1:1]};
              stack_d[0] = res;
              depth_d    = depth_q - DW'(1);
            end
          end
          KEY_NEG: begin
            if (depth_q == '0) begin
              err_d = 1'b1;
            end else if (opb == MIN_NEG) begin
              o_flag_d = 1'b1;
            end else begin
              stack_d[0] = -opb;
            end
          end
          KEY_DROP: begin
            if (depth_q == '0) begin
              err_d = 1'b1;
            end else begin
              stack_d = {{WIDTH{1'b0}}, stack_q[DEPTH-1:1]};
              depth_d = depth_q - DW'(1);
            end
          end
          KEY_MUL: begin
`ifdef RPN_MUL_EN
            if (depth_q < DW'(2)) begin
              err_d = 1'b1;
            end else begin
              mul_start = 1'b1;
              mul_neg_d = opa[WIDTH-1] ^ opb[WIDTH-1];
              state_d   = MUL;
            end
`else
            err_d = 1'b1;
`endif
          end
          default: ;
        endcase
      end

      MUL: begin
`ifdef RPN_MUL_EN
        if (mul_done) begin
          state_d = IDLE;
          if ((sprod[2*WIDTH-1:WIDTH-1] != '0) && (sprod[2*WIDTH-1:WIDTH-1] != '1)) begin
            o_flag_d = 1'b1;
          end
          stack_d    = {{WIDTH{1'b0}}, stack_q[DEPTH-1:1]};
          stack_d[0] = sprod[WIDTH-1:0];
          depth_d    = depth_q - DW'(1);
        end
`else
        state_d = IDLE;
`endif
      end

      default: state_d = IDLE;
    endcase

    top_d = entering_d ? entry_d : ((depth_d != '0) ? stack_d[0] : '0);
  end

  // state register
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      stack_q     <= '0;
      depth_q     <= '0;
      entry_q     <= '0;
      entering_q  <= 1'b0;
      op_q        <= '0;
      o_flag_q    <= 1'b0;
      err_q       <= 1'b0;
      top_q       <= '0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      entry_q     <= entry_d;
      entering_q  <= entering_d;
      op_q        <= op_d;
      o_flag_q    <= o_flag_d;
      err_q       <= err_d;
      top_q       <= top_d;
      key_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.top       = top_q;
  assign bus.depth_cnt = depth_q;
  assign bus.o_flag    = o_flag_q;
  assign bus.err       = err_q;
  assign bus.key_ready = key_ready_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rpn_calc_core.sv
// tb_rpn_calc_core: directed scenarios plus random key streams for rpn_calc_core,
// checked against a queue-based behavioural calculator model.
module tb_rpn_calc_core;
  import rpn_pkg::*;

  localparam int W    = 8;
  localparam int D    = 4;
  localparam int MAXP = (1 << (W - 1)) - 1;
  localparam int MINN = -(1 << (W - 1));
`ifdef RPN_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  rpn_calc_core_if #(.WIDTH(W), .DEPTH(D)) bus ();

  rpn_calc_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int stk[$];
  int m_entry;
  bit m_entering, m_oflag, m_err;

  int n_vec, n_fail;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wrap(input int v);
    int m;
    m = v & ((1 << W) - 1);
    if (m > MAXP) m -= (1 << W);
    return m;
  endfunction

  function automatic bit fits(input int v);
    return (v >= MINN) && (v <= MAXP);
  endfunction

  task automatic model_reset();
    stk.delete();
    m_entry    = 0;
    m_entering = 1'b0;
    m_oflag    = 1'b0;
    m_err      = 1'b0;
  endtask

  // applies one accepted key; exp_busy = cycles the block should stay busy
  task automatic model_key(input int code, output int exp_busy);
    int e, a, b, r;
    exp_busy = 0;
    if (code <= 9) begin
      e = m_entry * 10 + code;
      if (e > MAXP) begin
        m_entry = MAXP;
        m_oflag = 1'b1;
      end else begin
        m_entry = e;
      end
      m_entering = 1'b1;
    end else if (code == int'(KEY_CLEAR)) begin
      model_reset();
    end else if (code == int'(KEY_ENTER)) begin
      if (m_entering) begin
        m_entering = 1'b0;
        e = m_entry;
        m_entry = 0;
        if (stk.size() == D) m_err = 1'b1;
        else stk.push_front(e);
      end else if (stk.size() > 0) begin
        if (stk.size() == D) m_err = 1'b1;
        else stk.push_front(stk[0]);
      end
    end else if (code <= int'(KEY_DROP)) begin
      if (m_entering) begin
        m_entering = 1'b0;
        e = m_entry;
        m_entry = 0;
        if (stk.size() == D) begin
          m_err = 1'b1;
          return;
        end
        stk.push_front(e);
      end
      exp_busy = 1;
      if (code == int'(KEY_ADD) || code == int'(KEY_SUB)) begin
        if (stk.size() < 2) m_err = 1'b1;
        else begin
          b = stk.pop_front();
          a = stk.pop_front();
          r = (code == int'(KEY_ADD)) ? a + b : a - b;
          if (!fits(r)) m_oflag = 1'b1;
          stk.push_front(wrap(r));
        end
      end else if (code == int'(KEY_NEG)) begin
        if (stk.size() < 1) m_err = 1'b1;
        else if (stk[0] == MINN) m_oflag = 1'b1;
        else stk[0] = -stk[0];
      end else if (code == int'(KEY_DROP)) begin
        if (stk.size() < 1) m_err = 1'b1;
        else b = stk.pop_front();
      end else begin
        if (!MUL_EN || stk.size() < 2) m_err = 1'b1;
        else begin
          b = stk.pop_front();
          a = stk.pop_front();
          r = a * b;
          if (!fits(r)) m_oflag = 1'b1;
          stk.push_front(wrap(r));
          exp_busy = W + 1;
        end
      end
    end
  endtask

  function automatic logic [63:0] exp_top();
    int v;
    v = m_entering ? m_entry : ((stk.size() > 0) ? stk[0] : 0);
    return 64'(v & ((1 << W) - 1));
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".top"},    64'(bus.top),       exp_top());
    check_eq({tag, ".depth"},  64'(bus.depth_cnt), 64'(stk.size()));
    check_eq({tag, ".o_flag"}, 64'(bus.o_flag),    64'(m_oflag));
    check_eq({tag, ".err"},    64'(bus.err),       64'(m_err));
    check_eq({tag, ".busy"},   64'(bus.busy),      64'(0));
    check_eq({tag, ".ready"},  64'(bus.key_ready), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, ".top"},    64'(bus.top),       64'(0));
    check_eq({tag, ".depth"},  64'(bus.depth_cnt), 64'(0));
    check_eq({tag, ".o_flag"}, 64'(bus.o_flag),    64'(0));
    check_eq({tag, ".err"},    64'(bus.err),       64'(0));
    check_eq({tag, ".busy"},   64'(bus.busy),      64'(0));
    check_eq({tag, ".ready"},  64'(bus.key_ready), 64'(1));
  endtask

  // strobe one key, optionally strobe ENTER at busy cycle inj_at (must be dropped)
  task automatic press(input int code, input int inj_at, input string tag);
    int exp_b, nb, nr, g;
    model_key(code, exp_b);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = 5'(code);
    @(negedge clk);
    bus.key_valid = 1'b0;
    nb = 0;
    nr = 0;
    g  = 0;
    while (!bus.key_ready && g < 64) begin
      nr++;
      if (bus.busy) nb++;
      if (g == inj_at) begin
        bus.key_valid = 1'b1;
        bus.key_code  = KEY_ENTER;
      end else begin
        bus.key_valid = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    bus.key_valid = 1'b0;
    check_eq({tag, ".ready_low"},   64'(nr), 64'(exp_b));
    check_eq({tag, ".busy_cycles"}, 64'(nb), 64'(exp_b));
    check_outputs(tag);
  endtask

  task automatic press_seq(input int codes[$], input string tag);
    foreach (codes[i]) press(codes[i], -1, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_fail = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    nrst = 1'b1;
    @(negedge clk);

    // 12 ENTER 3 ADD
    press_seq('{1, 2, 14, 3}, "add_seq");
    press(int'(KEY_ADD), -1, "add");
    check_eq("add.top_const", 64'(bus.top), 64'(15));
    check_eq("add.depth_const", 64'(bus.depth_cnt), 64'(1));
    press(int'(KEY_CLEAR), -1, "clr1");

    // 100 ENTER 2 MUL with a dropped key mid-multiply
    press_seq('{1, 0, 0, 14, 2}, "mul_seq");
    press(int'(KEY_MUL), 3, "mul");
    if (MUL_EN) begin
      check_eq("mul.top_const", 64'(bus.top), 64'(8'hC8));
      check_eq("mul.oflag_const", 64'(bus.o_flag), 64'(1));
      check_eq("mul.depth_const", 64'(bus.depth_cnt), 64'(1));
    end else begin
      check_eq("mul.err_const", 64'(bus.err), 64'(1));
      check_eq("mul.depth_const", 64'(bus.depth_cnt), 64'(2));
    end
    press(int'(KEY_CLEAR), -1, "clr2");

    // implicit push then ADD with a single operand
    press_seq('{5, 10}, "underflow");
    check_eq("underflow.err_const", 64'(bus.err), 64'(1));
    check_eq("underflow.top_const", 64'(bus.top), 64'(5));
    press(int'(KEY_CLEAR), -1, "clr3");

    // overfill: 11,22,33,44,55 each followed by ENTER
    for (int i = 1; i <= 5; i++) press_seq('{i, i, 14}, "fill");
    check_eq("fill.top_const", 64'(bus.top), 64'(44));
    check_eq("fill.depth_const", 64'(bus.depth_cnt), 64'(4));
    press(int'(KEY_CLEAR), -1, "clr4");
    check_reset_values("after_clear");

    // entry saturation and NEG round trip
    press_seq('{1, 2, 8}, "sat");
    check_eq("sat.top_const", 64'(bus.top), 64'(127));
    press_seq('{14, 13, 13}, "negneg");
    check_eq("negneg.top_const", 64'(bus.top), 64'(127));
    check_eq("negneg.oflag_const", 64'(bus.o_flag), 64'(1));
    press(int'(KEY_CLEAR), -1, "clr5");

    // reset pulsed while an operation is in flight
    press_seq('{1, 0, 0, 14, 2}, "rst_seq");
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = KEY_MUL;
    @(negedge clk);
    bus.key_valid = 1'b0;
    if (MUL_EN) repeat (3) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check_reset_values("rst_mid");
    nrst = 1'b1;
    model_reset();

    // 3 ENTER 4 MUL
    press_seq('{3, 14, 4, 12}, "mul34");
    check_eq("mul34.top_const", 64'(bus.top), MUL_EN ? 64'(12) : 64'(4));

    // random key stream
    for (int i = 0; i < 400; i++) begin
      int r, code;
      r = int'($urandom_range(0, 99));
      if (r < 45)      code = int'($urandom_range(0, 9));
      else if (r < 60) code = int'(KEY_ENTER);
      else if (r < 93) code = int'($urandom_range(10, 15));
      else if (r < 96) code = int'(KEY_CLEAR);
      else             code = int'($urandom_range(17, 31));
      press(code, -1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
